onehot_to_bin_enc: RTL and testbench

Registered one-hot to binary encoder with a valid/ready handshake. It is the return path for the binary-to-one-hot decoder: one-hot grant/select vectors are converted back to an index. It also classifies malformed codes (all-zero or multi-hot) and keeps a saturating error count for debug visibility. It sits between a one-hot producer (arbiter grant, decoder output) and a binary-index consumer.

---
 rtl/onehot_to_bin_enc.sv | 78 +++++++
 tb/tb_onehot_to_bin_enc.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/onehot_to_bin_enc.sv
// rtl/onehot_to_bin_enc.sv - registered one-hot to binary encoder with malformed-code flags and saturating error count
module onehot_to_bin_enc #(
    parameter int BIN_W     = 4,
    parameter int ONE_HOT_W = 16,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [ONE_HOT_W-1:0] one_hot_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [BIN_W-1:0]     bin_o,
    output logic                 err_zero_o,
    output logic                 err_multi_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o,
    input  logic                 err_clr_i
);

    generate
        if (ONE_HOT_W != (1 << BIN_W)) begin : g_width_check
            $error("ONE_HOT_W must equal 2**BIN_W");
        end
    endgenerate

    logic [BIN_W-1:0] enc_idx;
    logic             enc_zero;
    logic             enc_multi;
    logic             accept;
    logic             consume;

    // Scan from the top so the lowest set bit is the last assignment to win.
    always_comb begin
        enc_idx = '0;
        for (int i = ONE_HOT_W - 1; i >= 0; i--) begin
            if (one_hot_i[i]) begin
                enc_idx = BIN_W'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves something only if more than one bit was set.
    assign enc_zero  = ~|one_hot_i;
    assign enc_multi = |(one_hot_i & (one_hot_i - ONE_HOT_W'(1)));

    assign ready_o = !valid_o || ready_i;
    assign accept  = valid_i && ready_o;
    assign consume = valid_o && ready_i;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_o     <= 1'b0;
            bin_o       <= '0;
            err_zero_o  <= 1'b0;
            err_multi_o <= 1'b0;
        end else if (accept) begin
            valid_o     <= 1'b1;
            bin_o       <= enc_idx;
            err_zero_o  <= enc_zero;
            err_multi_o <= enc_multi;
        end else if (consume) begin
            valid_o     <= 1'b0;
        end
    end

    // Clear wins over a same-cycle malformed accept; that event is not counted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt_o <= '0;
        end else if (err_clr_i) begin
            err_cnt_o <= '0;
        end else if (accept && (enc_zero || enc_multi) && (err_cnt_o != '1)) begin
            err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_onehot_to_bin_enc.sv
// tb/tb_onehot_to_bin_enc.sv - scoreboard bench for onehot_to_bin_enc with randomized traffic
module tb_onehot_to_bin_enc;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        valid_i;
    logic        ready_o;
    logic [15:0] one_hot_i;
    logic        valid_o;
    logic        ready_i;
    logic [3:0]  bin_o;
    logic        err_zero_o;
    logic        err_multi_o;
    logic [7:0]  err_cnt_o;
    logic        err_clr_i;

    onehot_to_bin_enc #(.BIN_W(4), .ONE_HOT_W(16), .ERR_CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .ready_o(ready_o),
        .one_hot_i(one_hot_i), .valid_o(valid_o), .ready_i(ready_i), .bin_o(bin_o),
        .err_zero_o(err_zero_o), .err_multi_o(err_multi_o), .err_cnt_o(err_cnt_o),
        .err_clr_i(err_clr_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] bin;
        logic       ez;
        logic       em;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    bit   running = 0;
    bit   exp_valid = 0;
    int   exp_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Lowest set bit isolated by two's complement, then its log2 is the index.
    function automatic logic [3:0] ref_bin(input logic [15:0] x);
        logic [15:0] low;
        low = x & (~x + 16'd1);
        return 4'($clog2(low));
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (running && reset_n) begin
                check("valid_o", 32'(valid_o), 32'(exp_valid));
                check("ready_o", 32'(ready_o), 32'(!exp_valid || ready_i));
                check("err_cnt_o", 32'(err_cnt_o), 32'(exp_cnt));
                if (valid_o) begin
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_output: got bin %0d expected none", bin_o);
                    end else begin
                        check("bin_o", 32'(bin_o), 32'(q[0].bin));
                        check("err_zero_o", 32'(err_zero_o), 32'(q[0].ez));
                        check("err_multi_o", 32'(err_multi_o), 32'(q[0].em));
                        if (ready_i) void'(q.pop_front());
                    end
                end
            end
        end
    end

    task automatic step(input logic v, input logic [15:0] oh, input logic r, input logic c);
        bit   acc;
        exp_t e;
        valid_i   = v;
        one_hot_i = oh;
        ready_i   = r;
        err_clr_i = c;
        @(negedge clk);
        #1;
        acc = v && (!exp_valid || r);
        if (acc) begin
            e.bin = ref_bin(oh);
            e.ez  = (oh == 16'd0);
            e.em  = ($countones(oh) > 1);
            q.push_back(e);
        end
        if (c) exp_cnt = 0;
        else if (acc && (oh == 16'd0 || $countones(oh) > 1) && exp_cnt < 255) exp_cnt++;
        if (acc) exp_valid = 1;
        else if (r) exp_valid = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] oh;
        int          sel;
        reset_n   = 1'b0;
        valid_i   = 1'b0;
        ready_i   = 1'b0;
        one_hot_i = '0;
        err_clr_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(valid_o), 0);
        check("rst_bin", 32'(bin_o), 0);
        check("rst_errs", 32'({err_zero_o, err_multi_o}), 0);
        check("rst_cnt", 32'(err_cnt_o), 0);
        reset_n = 1'b1;
        running = 1;

        for (int i = 0; i < 16; i++) step(1'b1, 16'(1) << i, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        step(1'b1, 16'h0000, 1'b1, 1'b0);
        step(1'b1, 16'h0014, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        check("cnt_after_malformed", 32'(err_cnt_o), 2);

        step(1'b1, 16'h0100, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 16'h0001, 1'b0, 1'b0);
        check("stall_bin", 32'(bin_o), 8);
        step(1'b1, 16'h0001, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        for (int i = 0; i < 260; i++) step(1'b1, 16'h0000, 1'b1, 1'b0);
        check("cnt_saturated", 32'(err_cnt_o), 255);
        step(1'b1, 16'h0000, 1'b1, 1'b1);
        check("cnt_clr_priority", 32'(err_cnt_o), 0);
        step(1'b0, '0, 1'b1, 1'b0);

        step(1'b1, 16'h0000, 1'b1, 1'b0);
        step(1'b1, 16'h0020, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        #1;
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(valid_o), 0);
        check("async_rst_bin", 32'(bin_o), 0);
        check("async_rst_errs", 32'({err_zero_o, err_multi_o}), 0);
        check("async_rst_cnt", 32'(err_cnt_o), 0);
        q.delete();
        exp_valid = 0;
        exp_cnt   = 0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(1'b1, 16'h0400, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0) oh = 16'h0000;
            else if (sel == 1) oh = 16'($urandom);
            else oh = 16'(1) << $urandom_range(0, 15);
            step(1'($urandom_range(0, 1)), oh, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 63) == 0));
        end
        repeat (3) step(1'b0, '0, 1'b1, 1'b0);
        check("queue_drained", 32'(q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
